ma_window_scheduler: RTL and testbench

//  Sequences the pipelined multiply/adder-tree convolution engine: walks every valid KxK window

---
 rtl/ma_window_scheduler_pkg.sv | 27 ++
 rtl/ma_window_scheduler_if.sv | 37 +++
 rtl/ma_window_scheduler_tag_fifo.sv | 60 ++++++
 rtl/ma_window_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_ma_window_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ma_window_scheduler_pkg.sv
// ma_window_scheduler_pkg
// Shared sizing and state type for the convolution window scheduler.
// Engine-facing sizes mirror the values kept in network_parms.h (product
// width, kernel size, engine latency and output FIFO depth) so the block
// builds standalone.

package ma_window_scheduler_pkg;

   localparam int PKG_PRODUCT_W   = 16;
   localparam int PKG_KERNEL_SIZE = 3;
   localparam int PKG_MA_LATENCY  = 5;
   localparam int PKG_OUT_DEPTH   = 8;

   localparam int PKG_NUM_KERNELS = 4;
   localparam int PKG_DIM_W       = 8;
   localparam int PKG_RES_W       = PKG_PRODUCT_W + 1;
   localparam int PKG_KERN_W      = (PKG_NUM_KERNELS > 1) ? $clog2(PKG_NUM_KERNELS) : 1;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/ma_window_scheduler_if.sv
// ma_window_scheduler_if
// Window request / engine issue / tagged result stream between the scheduler
// (master) and the surrounding datapath: line buffer, kernel ROM, MAC engine
// and the pooling stage (slave).

interface ma_window_scheduler_if
   import ma_window_scheduler_pkg::*;
#(
   parameter int DIM_W  = PKG_DIM_W,
   parameter int KERN_W = PKG_KERN_W,
   parameter int RES_W  = PKG_RES_W
);
   logic [DIM_W-1:0]  win_row;
   logic [DIM_W-1:0]  win_col;
   logic [KERN_W-1:0] kern_sel;
   logic              win_ready;
   logic              ma_issue;
   logic [RES_W-1:0]  ma_result;
   logic [RES_W-1:0]  res_data;
   logic [DIM_W-1:0]  res_row;
   logic [DIM_W-1:0]  res_col;
   logic [KERN_W-1:0] res_kern;
   logic              res_valid;
   logic              res_ready;

   modport master (
      output win_row, win_col, kern_sel, ma_issue,
      output res_data, res_row, res_col, res_kern, res_valid,
      input  win_ready, ma_result, res_ready
   );

   modport slave (
      input  win_row, win_col, kern_sel, ma_issue,
      input  res_data, res_row, res_col, res_kern, res_valid,
      output win_ready, ma_result, res_ready
   );
endinterface

// File: rtl/ma_window_scheduler_tag_fifo.sv
// ma_sched_tag_fifo
// Synchronous show-ahead FIFO holding engine sums with their window tags.
// The head is presented combinationally and forced to zero while empty so the
// result outputs read as zero after reset. Occupancy is exported for the
// scheduler's credit calculation.

module ma_sched_tag_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             valid,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && (count != CNT_W'(DEPTH));
   assign do_pop    = pop && (count != '0);
   assign valid     = (count != '0);
   assign head_data = valid ? mem[rd_ptr] : '0;

   // Storage array; contents need no reset because the head is masked when empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ma_window_scheduler.sv
// ma_window_scheduler
// Walks every valid KxK window of a feature map, time-sharing one pipelined
// multiply/adder-tree engine across NUM_KERNELS kernel banks. Each issue's
// {row,col,kern} tag rides a MA_LATENCY-deep shift register alongside the
// engine and is pushed with the engine sum into a tagged output FIFO.
// The engine cannot stall, so issue is gated by credit: FIFO slots not
// already claimed by stored or in-flight results.
// Optional build macro: MA_SCHED_PERF_CNT_EN adds the stall_cnt output.

module ma_window_scheduler
   import ma_window_scheduler_pkg::*;
#(
   parameter int KERNEL_SIZE = PKG_KERNEL_SIZE,
   parameter int NUM_KERNELS = PKG_NUM_KERNELS,
   parameter int DIM_W       = PKG_DIM_W,
   parameter int MA_LATENCY  = PKG_MA_LATENCY,
   parameter int OUT_DEPTH   = PKG_OUT_DEPTH
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_img_w,
   input  logic [DIM_W-1:0] cfg_img_h,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
`ifdef MA_SCHED_PERF_CNT_EN
   output logic [31:0]      stall_cnt,
`endif
   ma_window_scheduler_if.master bus
);
   localparam int KERN_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
   localparam int RES_W  = PKG_RES_W;
   localparam int OCC_W  = $clog2(OUT_DEPTH + MA_LATENCY + 1);
   localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
   localparam int TAG_W  = RES_W + 2 * DIM_W + KERN_W;

   localparam logic [DIM_W-1:0]  K_DIM     = DIM_W'(KERNEL_SIZE);
   localparam logic [KERN_W-1:0] LAST_KERN = KERN_W'(NUM_KERNELS - 1);
   localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(OUT_DEPTH);

   sched_state_t      state;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [KERN_W-1:0] kern_q;
   logic [DIM_W-1:0]  last_row;
   logic [DIM_W-1:0]  last_col;

   logic              tag_valid [MA_LATENCY];
   logic [DIM_W-1:0]  tag_row   [MA_LATENCY];
   logic [DIM_W-1:0]  tag_col   [MA_LATENCY];
   logic [KERN_W-1:0] tag_kern  [MA_LATENCY];

   logic [OCC_W-1:0]  inflight;
   logic [OCC_W-1:0]  occupancy;
   logic [CNT_W-1:0]  fifo_count;
   logic              has_credit;
   logic              issue;
   logic              last_issue;
   logic              fifo_valid;
   logic              fifo_pop;
   logic [TAG_W-1:0]  fifo_push_data;
   logic [TAG_W-1:0]  fifo_head;

   // Count results still travelling through the engine.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MA_LATENCY; i++) begin
         inflight = inflight + OCC_W'(tag_valid[i]);
      end
   end

   assign occupancy  = OCC_W'(fifo_count) + inflight;
   assign has_credit = (occupancy < DEPTH_OCC);
   assign issue      = (state == ST_ISSUE) && bus.win_ready && has_credit;
   assign last_issue = (kern_q == LAST_KERN) && (col_q == last_col) && (row_q == last_row);

   assign bus.win_row  = row_q;
   assign bus.win_col  = col_q;
   assign bus.kern_sel = kern_q;
   assign bus.ma_issue = issue;

   // Frame FSM with position/kernel counters; kernel is innermost, then column, then row.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         kern_q   <= '0;
         last_row <= '0;
         last_col <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done    <= 1'b0;
               cfg_err <= 1'b0;
               if (start) begin
                  busy     <= 1'b1;
                  row_q    <= '0;
                  col_q    <= '0;
                  kern_q   <= '0;
                  last_col <= cfg_img_w - K_DIM;
                  last_row <= cfg_img_h - K_DIM;
                  if ((cfg_img_w < K_DIM) || (cfg_img_h < K_DIM)) begin
                     state   <= ST_DONE;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (issue) begin
                  if (last_issue) begin
                     state  <= ST_DRAIN;
                     row_q  <= '0;
                     col_q  <= '0;
                     kern_q <= '0;
                  end else if (kern_q == LAST_KERN) begin
                     kern_q <= '0;
                     if (col_q == last_col) begin
                        col_q <= '0;
                        row_q <= row_q + DIM_W'(1);
                     end else begin
                        col_q <= col_q + DIM_W'(1);
                     end
                  end else begin
                     kern_q <= kern_q + KERN_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if ((inflight == '0) && (fifo_count == '0)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               cfg_err <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Tag shift register matching the engine latency; reset discards in-flight work.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MA_LATENCY; i++) begin
            tag_valid[i] <= 1'b0;
            tag_row[i]   <= '0;
            tag_col[i]   <= '0;
            tag_kern[i]  <= '0;
         end
      end else begin
         tag_valid[0] <= issue;
         tag_row[0]   <= row_q;
         tag_col[0]   <= col_q;
         tag_kern[0]  <= kern_q;
         for (int i = 1; i < MA_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_row[i]   <= tag_row[i-1];
            tag_col[i]   <= tag_col[i-1];
            tag_kern[i]  <= tag_kern[i-1];
         end
      end
   end

   assign fifo_push_data = {bus.ma_result, tag_row[MA_LATENCY-1],
                            tag_col[MA_LATENCY-1], tag_kern[MA_LATENCY-1]};
   assign fifo_pop       = fifo_valid && bus.res_ready;

   ma_sched_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tag_valid[MA_LATENCY-1]),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign bus.res_data  = fifo_head[TAG_W-1 -: RES_W];
   assign bus.res_row   = fifo_head[2*DIM_W+KERN_W-1 -: DIM_W];
   assign bus.res_col   = fifo_head[DIM_W+KERN_W-1 -: DIM_W];
   assign bus.res_kern  = fifo_head[KERN_W-1:0];
   assign bus.res_valid = fifo_valid;

`ifdef MA_SCHED_PERF_CNT_EN
   // Saturating count of cycles where a window was ready but no FIFO credit remained.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if ((state == ST_IDLE) && start) begin
         stall_cnt <= '0;
      end else if ((state == ST_ISSUE) && bus.win_ready && !has_credit && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ma_window_scheduler.sv
// tb_ma_window_scheduler
// Self-checking bench: table of frame configurations plus hand-written
// sequences for credit stall, cfg error timing, start-while-busy and
// mid-frame reset. A scoreboard queue receives the expected tag and engine
// sum on every issue and is checked as results pop.
// Build with MA_SCHED_PERF_CNT_EN defined to also exercise stall_cnt.

module tb_ma_window_scheduler;
   import ma_window_scheduler_pkg::*;

   localparam int K     = PKG_KERNEL_SIZE;
   localparam int NK    = PKG_NUM_KERNELS;
   localparam int DW    = PKG_DIM_W;
   localparam int RW    = PKG_RES_W;
   localparam int LAT   = PKG_MA_LATENCY;
   localparam int DEPTH = PKG_OUT_DEPTH;

   typedef struct {
      logic [RW-1:0] data;
      int            row;
      int            col;
      int            kern;
   } exp_t;

   typedef struct {
      int w;
      int h;
      int win_mode;
      int res_mode;
      int exp_issues;
      bit exp_err;
   } vec_t;

   logic          clock;
   logic          reset;
   logic          start;
   logic [DW-1:0] cfg_img_w;
   logic [DW-1:0] cfg_img_h;
   logic          busy;
   logic          done;
   logic          cfg_err;
`ifdef MA_SCHED_PERF_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   ma_window_scheduler_if bus_if ();

   ma_window_scheduler dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .cfg_img_w (cfg_img_w),
      .cfg_img_h (cfg_img_h),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
`ifdef MA_SCHED_PERF_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .bus       (bus_if)
   );

   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   cyc          = 0;
   int   win_mode     = 0;
   int   res_mode     = 0;
   int   issue_cnt    = 0;
   int   pop_cnt      = 0;
   int   done_cnt     = 0;
   bit   err_seen     = 1'b0;
   int   first_issue  = -1;
   int   first_valid  = -1;
   int   model_w      = 0;
   int   exp_row      = 0;
   int   exp_col      = 0;
   int   exp_kern     = 0;
   exp_t sb [$];
   exp_t mon_e;
   vec_t vecs [8];

   function automatic logic [RW-1:0] eng_val(input int c);
      return RW'(c * 37 + 11);
   endfunction

   function automatic logic [63:0] tagword(input int r, input int c, input int k);
      return (64'(r) << 24) | (64'(c) << 8) | 64'(k);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Engine sum, window-ready and consumer-ready drivers, updated just after each rising edge.
   always @(posedge clock) begin
      cyc = cyc + 1;
      #1;
      bus_if.ma_result = eng_val(cyc);
      case (win_mode)
         0:       bus_if.win_ready = 1'b1;
         1:       bus_if.win_ready = cyc[0];
         default: bus_if.win_ready = 1'($urandom_range(0, 1));
      endcase
      case (res_mode)
         0:       bus_if.res_ready = 1'b1;
         3:       bus_if.res_ready = 1'b0;
         default: bus_if.res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor on the falling edge: scoreboard push on issue, pop-and-compare on result handshake.
   always @(negedge clock) begin
      if (reset) begin
         if (bus_if.ma_issue) begin
            checkOutput("issue_win_ready", 64'(bus_if.win_ready), 64'd1);
            checkOutput("issue_credit", 64'((issue_cnt - pop_cnt) < DEPTH), 64'd1);
            checkOutput("issue_tag",
                        tagword(int'(bus_if.win_row), int'(bus_if.win_col), int'(bus_if.kern_sel)),
                        tagword(exp_row, exp_col, exp_kern));
            sb.push_back('{eng_val(cyc + LAT), exp_row, exp_col, exp_kern});
            if (first_issue < 0) first_issue = cyc;
            issue_cnt++;
            if (exp_kern == NK - 1) begin
               exp_kern = 0;
               if (exp_col == model_w - K) begin
                  exp_col = 0;
                  exp_row++;
               end else begin
                  exp_col++;
               end
            end else begin
               exp_kern++;
            end
         end
         if (bus_if.res_valid && (first_valid < 0)) first_valid = cyc;
         if (bus_if.res_valid && bus_if.res_ready) begin
            if (sb.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_result: got tag %0h with nothing outstanding",
                        tagword(int'(bus_if.res_row), int'(bus_if.res_col), int'(bus_if.res_kern)));
            end else begin
               mon_e = sb.pop_front();
               checkOutput("res_data", 64'(bus_if.res_data), 64'(mon_e.data));
               checkOutput("res_tag",
                           tagword(int'(bus_if.res_row), int'(bus_if.res_col), int'(bus_if.res_kern)),
                           tagword(mon_e.row, mon_e.col, mon_e.kern));
            end
            pop_cnt++;
         end
         if (done) begin
            done_cnt++;
            err_seen = cfg_err;
         end
      end
   end

   task automatic startFrame(input int w, input int h);
      model_w     = w;
      exp_row     = 0;
      exp_col     = 0;
      exp_kern    = 0;
      issue_cnt   = 0;
      pop_cnt     = 0;
      done_cnt    = 0;
      err_seen    = 1'b0;
      first_issue = -1;
      first_valid = -1;
      sb.delete();
      @(posedge clock); #1;
      cfg_img_w = DW'(w);
      cfg_img_h = DW'(h);
      start     = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
`ifdef MA_SCHED_PERF_CNT_EN
      @(negedge clock);
      checkOutput("stall_cnt_after_start", 64'(stall_cnt), 64'd0);
`endif
   endtask

   task automatic waitDone(input int budget);
      for (int i = 0; (i < budget) && (done_cnt == 0); i++) @(posedge clock);
      if (done_cnt == 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL done_timeout: done count 0 after %0d cycles, required 1", budget);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic checkFrame(input int exp_issues, input bit exp_err);
      checkOutput("frame_issues", 64'(issue_cnt), 64'(exp_issues));
      checkOutput("frame_results", 64'(pop_cnt), 64'(exp_issues));
      checkOutput("frame_done_once", 64'(done_cnt), 64'd1);
      checkOutput("frame_cfg_err", 64'(err_seen), 64'(exp_err));
      checkOutput("frame_sb_empty", 64'(sb.size()), 64'd0);
      checkOutput("frame_idle", {62'd0, busy, bus_if.res_valid}, 64'd0);
      if (exp_issues > 0) begin
         checkOutput("frame_latency", 64'(first_valid - first_issue), 64'(LAT + 1));
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      win_mode = v.win_mode;
      res_mode = v.res_mode;
      startFrame(v.w, v.h);
      waitDone(2000);
      checkFrame(v.exp_issues, v.exp_err);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      cfg_img_w = '0;
      cfg_img_h = '0;

      vecs[0] = '{4, 4, 0, 0, 16, 1'b0};
      vecs[1] = '{2, 4, 0, 0,  0, 1'b1};
      vecs[2] = '{4, 2, 0, 0,  0, 1'b1};
      vecs[3] = '{3, 3, 0, 0,  4, 1'b0};
      vecs[4] = '{5, 4, 0, 0, 24, 1'b0};
      vecs[5] = '{4, 4, 1, 0, 16, 1'b0};
      vecs[6] = '{4, 4, 0, 2, 16, 1'b0};
      vecs[7] = '{6, 3, 2, 2, 16, 1'b0};

      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_outputs",
                  64'({busy, done, cfg_err, bus_if.ma_issue, bus_if.res_valid,
                       bus_if.win_row, bus_if.win_col, bus_if.kern_sel, bus_if.res_data}),
                  64'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      for (int i = 0; i < 8; i++) begin
         $display("[TB] vector %0d: %0dx%0d win_mode=%0d res_mode=%0d", i,
                  vecs[i].w, vecs[i].h, vecs[i].win_mode, vecs[i].res_mode);
         applyStimulus(vecs[i]);
      end

      $display("[TB] cfg error timing");
      win_mode  = 0;
      res_mode  = 0;
      done_cnt  = 0;
      issue_cnt = 0;
      @(posedge clock); #1;
      cfg_img_w = DW'(2);
      cfg_img_h = DW'(4);
      start     = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
      @(negedge clock);
      checkOutput("err_done_cycle", {60'd0, busy, done, cfg_err, bus_if.ma_issue}, 64'b1110);
      @(negedge clock);
      checkOutput("err_after_done", {61'd0, busy, done, cfg_err}, 64'd0);
      checkOutput("err_no_issue", 64'(issue_cnt), 64'd0);

      $display("[TB] credit stall with consumer held off");
      win_mode = 0;
      res_mode = 3;
      startFrame(4, 4);
      repeat (40) @(posedge clock);
      @(negedge clock);
      checkOutput("hold_issue_count", 64'(issue_cnt), 64'(DEPTH));
      checkOutput("hold_state", {62'd0, busy, bus_if.res_valid}, 64'b11);
`ifdef MA_SCHED_PERF_CNT_EN
      checkOutput("hold_stall_cnt_nonzero", 64'(stall_cnt != 32'd0), 64'd1);
`endif
      res_mode = 0;
      waitDone(2000);
      checkFrame(16, 1'b0);

      $display("[TB] start while busy is ignored");
      startFrame(4, 4);
      repeat (3) @(posedge clock); #1;
      cfg_img_w = DW'(6);
      cfg_img_h = DW'(6);
      start     = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
      waitDone(2000);
      checkFrame(16, 1'b0);

      $display("[TB] reset in the middle of a frame");
      res_mode = 3;
      startFrame(4, 4);
      repeat (10) @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midreset_outputs",
                  {61'd0, busy, bus_if.ma_issue, bus_if.res_valid}, 64'd0);
      sb.delete();
      @(posedge clock); #1;
      reset    = 1'b1;
      res_mode = 0;
      applyStimulus('{4, 4, 0, 0, 16, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
